// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared constants for the UART TX FIFO drain: state encoding and
//          frame geometry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS            = 8;

  // Transmitter state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] PARITY = 3'd5;
  localparam logic [2:0] STOP   = 3'd6;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module : uart_baud_counter
// Brief  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last
//          clock of each bit period; wraps to zero on every bit boundary.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  // Next count: hold at zero while cleared, wrap at the end of each bit
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
// ============================================================================
// Module : uart_tx_fifo_drain
// Brief  : Pops one byte from a registered-output TX FIFO and serialises it
//          as start bit, 8 data bits LSB first, optional parity, 1 or 2
//          stop bits. Line idles high; tx is registered.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_data,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frame_count
);

  localparam logic [2:0] LAST_IDX   = 3'(DATA_BITS - 1);
  localparam logic [2:0] AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;
  localparam logic       ODD_BIT    = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic       STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  logic [2:0]  state_q,       state_d;
  logic [7:0]  shreg_q,       shreg_d;
  logic [2:0]  idx_q,         idx_d;
  logic        stop_idx_q,    stop_idx_d;
  logic        parity_q,      parity_d;
  logic        tx_q,          tx_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        done_w;
  logic        bit_end;
  logic        baud_clear;

  // The baud timer only runs while a bit is on the line
  assign baud_clear = (state_q == IDLE) || (state_q == READ) || (state_q == LOAD);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  // Frame sequencing; tx is computed from the next state so the pin is registered
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    idx_d         = idx_q;
    stop_idx_d    = stop_idx_q;
    parity_d      = parity_q;
    frame_count_d = frame_count_q;
    done_w        = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = LOAD;
      end
      LOAD: begin
        // FIFO read data is valid this cycle, one clock after the pop strobe
        shreg_d    = fifo_data;
        parity_d   = (^fifo_data) ^ ODD_BIT;
        idx_d      = 3'd0;
        stop_idx_d = 1'b0;
        state_d    = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = AFTER_DATA;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            state_d       = IDLE;
            done_w        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[idx_d];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops the frame and idles the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= 8'd0;
      idx_q         <= 3'd0;
      stop_idx_q    <= 1'b0;
      parity_q      <= 1'b0;
      tx_q          <= 1'b1;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      idx_q         <= idx_d;
      stop_idx_q    <= stop_idx_d;
      parity_q      <= parity_d;
      tx_q          <= tx_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign fifo_rd_en  = (state_q == READ);
  assign busy        = (state_q != IDLE);
  assign tx_done     = done_w;
  assign tx          = tx_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
// ============================================================================
// Module : tb_uart_tx_fifo_drain
// Brief  : Self-checking bench for uart_tx_fifo_drain with a FIFO model and
//          an expected-byte scoreboard; frames are compared sample by sample.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  // DUT A: no parity, 1 stop bit
  logic a_en = 1'b0, a_empty, a_rd, a_tx, a_busy, a_done;
  logic [7:0]  a_data = 8'h00;
  logic [15:0] a_fc;
  // DUT B: even parity, 2 stop bits
  logic b_en = 1'b0, b_empty, b_rd, b_tx, b_busy, b_done;
  logic [7:0]  b_data = 8'h00;
  logic [15:0] b_fc;

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .tx_enable(a_en), .fifo_empty(a_empty), .fifo_rd_en(a_rd),
    .fifo_data(a_data), .tx(a_tx), .busy(a_busy), .tx_done(a_done), .frame_count(a_fc));

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_p (
    .clk(clk), .reset(reset), .tx_enable(b_en), .fifo_empty(b_empty), .fifo_rd_en(b_rd),
    .fifo_data(b_data), .tx(b_tx), .busy(b_busy), .tx_done(b_done), .frame_count(b_fc));

  // FIFO models: registered read data, valid the cycle after the pop
  logic [7:0] a_mem [0:15];
  logic [7:0] b_mem [0:15];
  int a_wp = 0, a_rp = 0, b_wp = 0, b_rp = 0;
  assign a_empty = (a_wp == a_rp);
  assign b_empty = (b_wp == b_rp);
  always @(posedge clk) if (a_rd) begin a_data <= a_mem[a_rp % 16]; a_rp <= a_rp + 1; end
  always @(posedge clk) if (b_rd) begin b_data <= b_mem[b_rp % 16]; b_rp <= b_rp + 1; end

  // Pulse monitors
  int a_rd_cnt = 0, a_rd_cyc = 0, a_done_cnt = 0;
  always @(negedge clk) begin
    if (a_rd === 1'b1) begin a_rd_cnt <= a_rd_cnt + 1; a_rd_cyc <= cyc; end
    if (a_done === 1'b1) a_done_cnt <= a_done_cnt + 1;
  end

  // Scoreboard of bytes expected on the line
  logic [7:0] sb_q [$];

  task automatic push_a(input logic [7:0] b);
    a_mem[a_wp % 16] = b; a_wp = a_wp + 1; sb_q.push_back(b);
  endtask

  task automatic push_b(input logic [7:0] b);
    b_mem[b_wp % 16] = b; b_wp = b_wp + 1; sb_q.push_back(b);
  endtask

  function automatic int frame_samples(input bit pe, input int stops);
    return (9 + (pe ? 1 : 0) + stops) * CPB;
  endfunction

  // Reference line waveform, one entry per clock, from the UART frame format
  function automatic logic [63:0] exp_line(input logic [7:0] d, input bit pe, input bit podd, input int stops);
    logic [63:0] v;
    logic [11:0] bits;
    int nb;
    v = '0; bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (pe) begin bits[nb] = (^d) ^ podd; nb++; end
    for (int s = 0; s < stops; s++) begin bits[nb] = 1'b1; nb++; end
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < CPB; k++) v[b*CPB + k] = bits[b];
    return v;
  endfunction

  // Wait for a start bit then record tx and tx_done for nsamp clocks
  task automatic capture(input bit sel, input int nsamp, output logic [63:0] ln,
                         output logic [63:0] dn, output int start_cyc, output bit to);
    int waited;
    waited = 0; ln = '0; dn = '0; start_cyc = 0; to = 1'b0;
    @(negedge clk);
    while (((sel ? b_tx : a_tx) !== 1'b0) && waited < 300) begin
      @(negedge clk); waited++;
    end
    if (waited >= 300) begin to = 1'b1; return; end
    start_cyc = cyc;
    for (int i = 0; i < nsamp; i++) begin
      if (i > 0) @(negedge clk);
      ln[i] = sel ? b_tx : a_tx;
      dn[i] = sel ? b_done : a_done;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; a_en = 1'b0; b_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk);
    reset = 1'b1; a_en = 1'b1;
    #1;
    tests_run++; if (a_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx got %b want 1", a_tx); end
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", a_busy); end
    tests_run++; if (a_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_rd got %b want 0", a_rd); end
    tests_run++; if (a_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", a_done); end
    tests_run++; if (a_fc !== 16'd0) begin tests_failed++; $display("FAIL reset_fc got %0d want 0", a_fc); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_rd !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL empty_idle got %0d bad cycles want 0", bad); end
    a_en = 1'b0;
  endtask

  task automatic test_single();
    logic [63:0] ln, dn; int sc, rd0, dn0; bit to; logic [7:0] e; int n;
    do_reset();
    rd0 = a_rd_cnt; dn0 = a_done_cnt; n = frame_samples(0, 1);
    push_a(8'hA5); a_en = 1'b1;
    capture(1'b0, n, ln, dn, sc, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL single_start got timeout want start bit"); return; end
    e = sb_q.pop_front();
    if (ln !== exp_line(e, 0, 0, 1)) begin tests_failed++; $display("FAIL single_line got %h want %h", ln, exp_line(e, 0, 0, 1)); end
    tests_run++; if (dn !== (64'd1 << (n-1))) begin tests_failed++; $display("FAIL single_done got %h want %h", dn, 64'd1 << (n-1)); end
    tests_run++; if (sc - a_rd_cyc != 2) begin tests_failed++; $display("FAIL rd_to_start got %0d want 2", sc - a_rd_cyc); end
    repeat (2) @(negedge clk);
    tests_run++; if (a_rd_cnt - rd0 != 1) begin tests_failed++; $display("FAIL single_rd_pulses got %0d want 1", a_rd_cnt - rd0); end
    tests_run++; if (a_done_cnt - dn0 != 1) begin tests_failed++; $display("FAIL single_done_pulses got %0d want 1", a_done_cnt - dn0); end
    tests_run++; if (a_fc !== 16'd1) begin tests_failed++; $display("FAIL single_fc got %0d want 1", a_fc); end
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after got %b want 0", a_busy); end
  endtask

  task automatic test_parity();
    logic [63:0] ln, dn, ex; int sc; bit to; logic [7:0] e; int n;
    do_reset();
    n = frame_samples(1, 2);
    push_b(8'h07); b_en = 1'b1;
    capture(1'b1, n, ln, dn, sc, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL parity_start got timeout want start bit"); b_en = 1'b0; return; end
    e = sb_q.pop_front(); ex = exp_line(e, 1, 0, 2);
    if (ln !== ex) begin tests_failed++; $display("FAIL parity_line got %h want %h", ln, ex); end
    tests_run++; if (ln[39:36] !== 4'hF) begin tests_failed++; $display("FAIL parity_bit got %h want f", ln[39:36]); end
    tests_run++; if (ln[47:40] !== 8'hFF) begin tests_failed++; $display("FAIL stop2_width got %h want ff", ln[47:40]); end
    tests_run++; if (dn !== (64'd1 << (n-1))) begin tests_failed++; $display("FAIL parity_done got %h want %h", dn, 64'd1 << (n-1)); end
    repeat (2) @(negedge clk);
    tests_run++; if (b_fc !== 16'd1) begin tests_failed++; $display("FAIL parity_fc got %0d want 1", b_fc); end
    b_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ln, dn; int sc, prev_end, rd0, n; bit to; logic [7:0] e;
    do_reset();
    rd0 = a_rd_cnt; n = frame_samples(0, 1); prev_end = 0;
    push_a(8'h01); push_a(8'hFF); push_a(8'h80); a_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      capture(1'b0, n, ln, dn, sc, to);
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL b2b_start%0d got timeout want start bit", k); return; end
      e = sb_q.pop_front();
      if (ln !== exp_line(e, 0, 0, 1)) begin tests_failed++; $display("FAIL b2b_line%0d got %h want %h", k, ln, exp_line(e, 0, 0, 1)); end
      if (k > 0) begin
        tests_run++;
        if (sc - prev_end - 1 != 3) begin tests_failed++; $display("FAIL b2b_gap%0d got %0d want 3", k, sc - prev_end - 1); end
      end
      prev_end = sc + n - 1;
    end
    repeat (10) @(negedge clk);
    tests_run++; if (a_rd_cnt - rd0 != 3) begin tests_failed++; $display("FAIL b2b_rd_pulses got %0d want 3", a_rd_cnt - rd0); end
    tests_run++; if (a_fc !== 16'd3) begin tests_failed++; $display("FAIL b2b_fc got %0d want 3", a_fc); end
    a_en = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [63:0] ln, dn; int sc, rd0, n; bit to; logic [7:0] e;
    do_reset();
    rd0 = a_rd_cnt; n = frame_samples(0, 1);
    push_a(8'h3C); push_a(8'h55); a_en = 1'b1;
    fork
      capture(1'b0, n, ln, dn, sc, to);
      begin
        int w = 0;
        while (a_rd !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        repeat (2 + 16 + 1) @(negedge clk);
        a_en = 1'b0;
      end
    join
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL drop_start got timeout want start bit"); end
    else begin
      e = sb_q.pop_front();
      if (ln !== exp_line(e, 0, 0, 1)) begin tests_failed++; $display("FAIL drop_line got %h want %h", ln, exp_line(e, 0, 0, 1)); end
    end
    repeat (40) @(negedge clk);
    tests_run++; if (a_rd_cnt - rd0 != 1) begin tests_failed++; $display("FAIL drop_rd_pulses got %0d want 1", a_rd_cnt - rd0); end
    tests_run++; if (a_empty !== 1'b0) begin tests_failed++; $display("FAIL drop_pending got empty=%b want 0", a_empty); end
    tests_run++; if (a_fc !== 16'd1) begin tests_failed++; $display("FAIL drop_fc got %0d want 1", a_fc); end
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL drop_busy got %b want 0", a_busy); end
    // Discard the byte left in the FIFO
    a_wp = a_rp;
    while (sb_q.size() > 0) e = sb_q.pop_front();
  endtask

  task automatic test_reset_mid();
    logic [63:0] ln, dn; int sc, dn0, n, w; bit to; logic [7:0] e;
    do_reset();
    n = frame_samples(0, 1);
    push_a(8'h5A); push_a(8'hC3); a_en = 1'b1;
    w = 0;
    while (a_rd !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    repeat (2 + 24 + 1) @(negedge clk);
    tests_run++; if (a_tx !== 1'b0) begin tests_failed++; $display("FAIL mid_bit5 got %b want 0", a_tx); end
    dn0 = a_done_cnt;
    reset = 1'b1;
    #1;
    tests_run++; if (a_tx !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_tx got %b want 1", a_tx); end
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy got %b want 0", a_busy); end
    tests_run++; if (a_fc !== 16'd0) begin tests_failed++; $display("FAIL mid_reset_fc got %0d want 0", a_fc); end
    e = sb_q.pop_front();  // popped byte is lost
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests_run++; if (a_done_cnt != dn0) begin tests_failed++; $display("FAIL mid_reset_no_done got %0d pulses want 0", a_done_cnt - dn0); end
    capture(1'b0, n, ln, dn, sc, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL mid_next_start got timeout want start bit"); a_en = 1'b0; return; end
    e = sb_q.pop_front();
    if (ln !== exp_line(e, 0, 0, 1)) begin tests_failed++; $display("FAIL mid_next_line got %h want %h", ln, exp_line(e, 0, 0, 1)); end
    repeat (2) @(negedge clk);
    tests_run++; if (a_fc !== 16'd1) begin tests_failed++; $display("FAIL mid_next_fc got %0d want 1", a_fc); end
    a_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
